// File: rtl/env_adsr.sv
// ---------------------------------------------------------------------------
// env_adsr
//   ADSR envelope generator with a two-stage sample scaling pipeline.
//   The envelope advances once per sample tick. The incoming offset-binary
//   sample is re-centred and multiplied by the envelope, giving a result
//   two clocks after the tick.
//
// Ports
//   sys_clk        in   1        single clock, rising edge
//   rst            in   1        asynchronous active-high reset
//   tick           in   1        one-cycle sample strobe
//   gate           in   1        note gate, high while the key is held
//   attack_rate    in   RATE_W   attack step rate
//   decay_rate     in   RATE_W   decay step rate
//   release_rate   in   RATE_W   release step rate
//   sustain_lvl    in   RATE_W   sustain level, upper byte of the envelope
//   sample_in      in   WAVE_W   modulator sample, offset binary
//   sample_out     out  WAVE_W   enveloped sample, offset binary
//   out_valid      out  1        one-cycle strobe for a new sample_out
//   env_level      out  16       current envelope value
//   env_state      out  3        IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
// ---------------------------------------------------------------------------
module env_adsr #(
    parameter int WAVE_W = 16,
    parameter int RATE_W = 8
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              gate,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] decay_rate,
    input  logic [RATE_W-1:0] release_rate,
    input  logic [RATE_W-1:0] sustain_lvl,
    input  logic [WAVE_W-1:0] sample_in,
    output logic [WAVE_W-1:0] sample_out,
    output logic              out_valid,
    output logic [15:0]       env_level,
    output logic [2:0]        env_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [WAVE_W-1:0] MID = {1'b1, {(WAVE_W-1){1'b0}}};

    // Step size for a rate code: (r + 1) * 16, computed in 17 bits.
    function automatic logic [16:0] step_of(input logic [RATE_W-1:0] r);
        logic [16:0] s;
        s = 17'(r) + 17'd1;
        return s << 4;
    endfunction

    state_t        state_q, state_d;
    logic [15:0]   env_q, env_d;
    logic          gate_q;
    logic          rise, fall;
    logic [15:0]   target;
    logic [16:0]   att_sum, dec_diff, rel_diff;

    logic [WAVE_W-1:0]        centred_q;
    logic [15:0]              env_s1_q;
    logic                     valid_s1_q;
    logic signed [WAVE_W+16:0] product;
    logic [WAVE_W-1:0]        scaled;
    logic [WAVE_W-1:0]        sample_out_q;
    logic                     out_valid_q;

    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;

    assign target = 16'({sustain_lvl, 8'h00});

    // 17-bit arithmetic: bit 16 flags overflow on the add and a borrow on
    // the subtracts, so saturation never wraps.
    assign att_sum  = {1'b0, env_q} + step_of(attack_rate);
    assign dec_diff = {1'b0, env_q} - step_of(decay_rate);
    assign rel_diff = {1'b0, env_q} - step_of(release_rate);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            env_q   <= 16'h0000;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            gate_q  <= gate;
        end
    end

    // Gate edges win over a coincident tick: only the state changes then.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (rise) begin
            state_d = ATTACK;
        end else if (fall) begin
            if (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN) begin
                state_d = RELEASE;
            end
        end else if (tick) begin
            case (state_q)
                ATTACK: begin
                    if (att_sum >= 17'h0FFFF) begin
                        env_d   = 16'hFFFF;
                        state_d = DECAY;
                    end else begin
                        env_d = att_sum[15:0];
                    end
                end
                DECAY: begin
                    // Entering already at or below the target snaps to it.
                    if (env_q <= target || dec_diff[16] || dec_diff[15:0] <= target) begin
                        env_d   = target;
                        state_d = SUSTAIN;
                    end else begin
                        env_d = dec_diff[15:0];
                    end
                end
                SUSTAIN: begin
                    env_d = target;
                end
                RELEASE: begin
                    if (rel_diff[16] || rel_diff[15:0] == 16'h0000) begin
                        env_d   = 16'h0000;
                        state_d = IDLE;
                    end else begin
                        env_d = rel_diff[15:0];
                    end
                end
                default: begin
                    env_d   = 16'h0000;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Signed sample times unsigned envelope (zero-extended to keep it
    // positive); the arithmetic shift by 16 always fits back in WAVE_W bits.
    assign product = $signed(centred_q) * $signed({1'b0, env_s1_q});
    assign scaled  = WAVE_W'(product >>> 16);

    // Stage 1 captures the centred sample and the pre-update envelope on
    // tick; stage 2 produces the re-offset result and the valid strobe.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            centred_q    <= '0;
            env_s1_q     <= 16'h0000;
            valid_s1_q   <= 1'b0;
            sample_out_q <= MID;
            out_valid_q  <= 1'b0;
        end else begin
            valid_s1_q  <= tick;
            out_valid_q <= valid_s1_q;
            if (tick) begin
                centred_q <= sample_in - MID;
                env_s1_q  <= env_q;
            end
            if (valid_s1_q) begin
                sample_out_q <= MID + scaled;
            end
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign env_level  = env_q;
    assign env_state  = state_q;

endmodule

// File: tb/tb_env_adsr.sv
module tb_env_adsr;

    logic        sys_clk;
    logic        rst;
    logic        tick;
    logic        gate;
    logic [7:0]  attack_rate;
    logic [7:0]  decay_rate;
    logic [7:0]  release_rate;
    logic [7:0]  sustain_lvl;
    logic [15:0] sample_in;
    logic [15:0] sample_out;
    logic        out_valid;
    logic [15:0] env_level;
    logic [2:0]  env_state;

    int total;
    int bad;
    logic [15:0] sb[$];

    env_adsr #(.WAVE_W(16), .RATE_W(8)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .tick         (tick),
        .gate         (gate),
        .attack_rate  (attack_rate),
        .decay_rate   (decay_rate),
        .release_rate (release_rate),
        .sustain_lvl  (sustain_lvl),
        .sample_in    (sample_in),
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .env_level    (env_level),
        .env_state    (env_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Single comparison point; every check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic checkEnv(input string name, input logic [2:0] st, input logic [15:0] env);
        checkOutput({name, " state"}, {29'd0, env_state}, {29'd0, st});
        checkOutput({name, " env"}, {16'd0, env_level}, {16'd0, env});
    endtask

    // One tick cycle: queue the expected sample, pulse tick, return at the
    // next falling edge when the envelope update is visible.
    task automatic applyStimulus(input logic [15:0] smp, input logic [15:0] exp);
        @(negedge sys_clk);
        tick = 1'b1;
        sample_in = smp;
        sb.push_back(exp);
        @(negedge sys_clk);
        tick = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic setGate(input logic v);
        @(negedge sys_clk);
        gate = v;
        @(negedge sys_clk);
    endtask

    // Monitor: pops an expectation every time the DUT strobes a sample.
    always @(negedge sys_clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL spurious out_valid: got=1 expected=0 sample_out=0x%0h", sample_out);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                checkOutput("sample_out", {16'd0, sample_out}, {16'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        tick = 1'b0;
        gate = 1'b0;
        attack_rate = 8'hFF;
        decay_rate = 8'hFF;
        release_rate = 8'hFF;
        sustain_lvl = 8'h80;
        sample_in = 16'h8000;

        idleCycles(3);
        checkEnv("reset", 3'd0, 16'h0000);
        checkOutput("reset sample_out", {16'd0, sample_out}, 32'h8000);
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge sys_clk);
        rst = 1'b0;
        idleCycles(2);
        checkEnv("idle after reset", 3'd0, 16'h0000);

        // Full-scale attack: 4096 per tick, saturate at 0xFFFF on tick 16.
        setGate(1'b1);
        checkEnv("gate rise", 3'd1, 16'h0000);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(16'h8000, 16'h8000);
            if (k < 16) checkEnv($sformatf("attack%0d", k), 3'd1, 16'(k * 4096));
            else        checkEnv("attack top", 3'd2, 16'hFFFF);
            idleCycles(2);
        end

        // Decay towards 0x8000: FFFF, EFFF ... 8FFF, then clamp.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(16'h8000, 16'h8000);
            if (k < 8) checkEnv($sformatf("decay%0d", k), 3'd2, 16'hFFFF - 16'(k * 4096));
            else       checkEnv("decay clamp", 3'd3, 16'h8000);
            idleCycles(2);
        end

        // Scaling and two-cycle latency at env=0x8000.
        applyStimulus(16'hFFFF, 16'hBFFF);
        checkOutput("latency +1 out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge sys_clk);
        checkOutput("latency +2 out_valid", {31'd0, out_valid}, 32'd1);
        @(negedge sys_clk);
        checkOutput("strobe width", {31'd0, out_valid}, 32'd0);
        checkOutput("sample hold", {16'd0, sample_out}, 32'hBFFF);
        applyStimulus(16'h0000, 16'h4000);
        idleCycles(2);

        // Sustain tracks level changes on each tick.
        sustain_lvl = 8'h40;
        applyStimulus(16'h8000, 16'h8000);
        checkEnv("sustain track", 3'd3, 16'h4000);
        idleCycles(2);
        applyStimulus(16'hFFFF, 16'h9FFF);
        idleCycles(2);

        // Release floor from 0x0100 with a 4096 step.
        sustain_lvl = 8'h01;
        applyStimulus(16'h8000, 16'h8000);
        checkEnv("sustain low", 3'd3, 16'h0100);
        setGate(1'b0);
        checkEnv("gate fall", 3'd4, 16'h0100);
        applyStimulus(16'h8000, 16'h8000);
        checkEnv("release floor", 3'd0, 16'h0000);
        idleCycles(2);
        applyStimulus(16'hFFFF, 16'h8000);
        checkEnv("idle hold", 3'd0, 16'h0000);
        idleCycles(2);

        // Build up a release in progress, then gate rise coincident with tick.
        setGate(1'b1);
        applyStimulus(16'h8000, 16'h8000);
        applyStimulus(16'h8000, 16'h8000);
        checkEnv("reattack", 3'd1, 16'h2000);
        setGate(1'b0);
        release_rate = 8'h0F;
        applyStimulus(16'h8000, 16'h8000);
        checkEnv("release step", 3'd4, 16'h1F00);
        idleCycles(2);
        @(negedge sys_clk);
        gate = 1'b1;
        tick = 1'b1;
        sample_in = 16'hFFFF;
        sb.push_back(16'h8F7F);
        @(negedge sys_clk);
        tick = 1'b0;
        checkEnv("gate/tick coincide", 3'd1, 16'h1F00);
        idleCycles(2);
        attack_rate = 8'h00;
        applyStimulus(16'h8000, 16'h8000);
        checkEnv("slow attack", 3'd1, 16'h1F10);
        idleCycles(3);

        // Reset mid-attack with a sample in flight.
        attack_rate = 8'hFF;
        @(negedge sys_clk);
        tick = 1'b1;
        sample_in = 16'hFFFF;
        @(negedge sys_clk);
        tick = 1'b0;
        rst = 1'b1;
        #1;
        checkEnv("async reset", 3'd0, 16'h0000);
        checkOutput("async reset sample_out", {16'd0, sample_out}, 32'h8000);
        checkOutput("async reset out_valid", {31'd0, out_valid}, 32'd0);
        idleCycles(2);
        checkOutput("reset no strobe", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        @(negedge sys_clk);
        checkEnv("gate held through reset", 3'd1, 16'h0000);

        // Back-to-back ticks at full rate.
        @(negedge sys_clk);
        tick = 1'b1;
        sample_in = 16'hFFFF;
        sb.push_back(16'h8000);
        @(negedge sys_clk);
        sb.push_back(16'h87FF);
        @(negedge sys_clk);
        sb.push_back(16'h8FFF);
        @(negedge sys_clk);
        tick = 1'b0;
        checkEnv("back-to-back", 3'd1, 16'h3000);
        idleCycles(4);

        checkOutput("scoreboard drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/env_adsr.md
ENV_ADSR -- requirements
Module: env_adsr

Interface
REQ-001 SHALL have parameter WAVE_W, default 16, sample width in bits (offset-binary, midscale 2^(WAVE_W-1)).
REQ-002 SHALL have parameter RATE_W, default 8, width of the rate and sustain controls.
REQ-003 SHALL have port sys_clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port tick  in  1  one-cycle sample strobe from the master divider.
REQ-006 SHALL have port gate  in  1  note gate, synchronous to sys_clk; high = key held.
REQ-007 SHALL have port attack_rate, decay_rate, release_rate  in  RATE_W each  step rates.
REQ-008 SHALL have port sustain_lvl  in  RATE_W  sustain level, upper byte of the envelope.
REQ-009 SHALL have port sample_in  in  WAVE_W  modulator output, valid when tick is high.
REQ-010 SHALL have port sample_out  out  WAVE_W  enveloped sample to the DAC serializer.
REQ-011 SHALL have port out_valid  out  1  one-cycle strobe marking a new sample_out.
REQ-012 SHALL have port env_level  out  16  current envelope value, unsigned.
REQ-013 SHALL have port env_state  out  3  encoding IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

Function
REQ-014 SHALL register gate into gate_q each cycle; rise = gate & ~gate_q, fall = ~gate & gate_q.
REQ-015 SHALL define step(r) = (r + 1) << 4, zero-extended to 16 bits (range 16..4096).
REQ-016 SHALL transition on rise from any state to ATTACK, keeping the current env (no restart from 0).
REQ-017 SHALL transition on fall from ATTACK, DECAY or SUSTAIN to RELEASE; fall in IDLE or RELEASE has no effect.
REQ-018 SHALL give gate events priority: in a cycle with rise/fall, apply the state change only and skip any env step on a coincident tick.
REQ-019 SHALL step env only on tick cycles without a gate event, per the following rules:
- ATTACK: env = min(env + step(attack_rate), 0xFFFF); on reaching 0xFFFF, next state DECAY.
- DECAY: target T = {sustain_lvl, 8'h00}; env = max(env - step(decay_rate), T) with no underflow; on reaching T, next state SUSTAIN.
- SUSTAIN: env = T, tracking sustain_lvl changes on each tick.
- RELEASE: env = max(env - step(release_rate), 0); on reaching 0, next state IDLE.
- IDLE: env held at 0.
REQ-020 SHALL use 17-bit intermediate arithmetic so saturation is exact with no wrap-around.
REQ-021 SHALL, when DECAY is entered with env <= T, set env = T and enter SUSTAIN on the first tick.
REQ-022 SHALL compute sample_out = 2^(WAVE_W-1) + (((sample_in - 2^(WAVE_W-1)) signed * env unsigned) >>> 16), as an arithmetic shift.
REQ-023 SHALL use the env value present in the tick cycle, before that tick's update.
REQ-024 SHALL pipeline in two stages:
- stage 1 registers the centred sample and env on tick;
- stage 2 registers the product;
- sample_out updates and out_valid pulses exactly 2 cycles after tick.
REQ-025 SHALL hold sample_out between strobes; out_valid SHALL be high for one cycle per tick.
REQ-026 SHALL accept back-to-back ticks (every cycle) at full throughput.
REQ-027 SHALL NOT mutate control inputs; rate changes take effect on the next tick.

Reset
REQ-028 SHALL, while rst is high, force state=IDLE, env=0, gate_q=0, pipeline valid bits=0, sample_out=2^(WAVE_W-1) (0x8000), out_valid=0, env_level=0.
REQ-029 SHALL abort a mid-operation envelope (any state) on rst and discard in-flight pipeline samples with no out_valid.
REQ-030 SHALL treat gate already high when rst falls as a rise on the first clock after release.

Verification
REQ-031 Full-scale attack: attack_rate=0xFF, gate rises, tick every 4 cycles -> env 4096, 8192, ... 0xFFFF after 16 ticks, then DECAY.
REQ-032 Decay to sustain: sustain_lvl=0x80, decay_rate=0xFF -> env clamps to exactly 0x8000, state SUSTAIN, no undershoot.
REQ-033 Release floor: gate falls at env=0x0100 with release_rate=0xFF -> env=0 and IDLE on the next tick, no wrap.
REQ-034 Scaling and latency: sample_in=0xFFFF with env=0x8000 -> sample_out=0xBFFF two cycles after tick; sample_in=0x0000 -> 0x4000.
REQ-035 Gate/tick coincidence: gate rises in the same cycle as tick during RELEASE -> state ATTACK, env unchanged that cycle.
REQ-036 Reset mid-ATTACK with samples in flight -> immediate IDLE, env=0, sample_out=0x8000, no out_valid pulse.
